// File: rtl/aes_key_sched.sv
// AES-128 key expansion: emits round keys 0..10 on 11 consecutive cycles
// after a start request, one round key per clock.
module aes_key_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [127:0] rk,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  output logic         busy,
  output logic         done
);

  localparam int unsigned KEY_W     = 128;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned LAST_IDX  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // FIPS-197 S-box, byte 0x00 in the most significant position
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_e           state_q;
  logic [KEY_W-1:0] rk_q;
  logic [IDX_W-1:0] idx_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic [KEY_W-1:0] rk_d;
  logic [IDX_W-1:0] idx_d;
  logic [7:0]       rcon;
  logic [31:0]      w0, w1, w2, w3;
  logic [31:0]      rot, t;
  logic [31:0]      n0, n1, n2, n3;

  // Byte b sits at bit offset 8*(255-b), i.e. {~b, 3'b000}
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] base;
    base = {~b, 3'b000};
    return SBOX_TBL[base +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  assign idx_d = idx_q + IDX_W'(1);

  // Round constant for the round being produced; zero outside 1..10
  always_comb begin
    rcon = 8'h00;
    case (idx_d)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // Next round key from the current one
  always_comb begin
    w0   = rk_q[127:96];
    w1   = rk_q[95:64];
    w2   = rk_q[63:32];
    w3   = rk_q[31:0];
    rot  = {w3[23:0], w3[31:24]};
    t    = sub_word(rot) ^ {rcon, 24'h000000};
    n0   = w0 ^ t;
    n1   = w1 ^ n0;
    n2   = w2 ^ n1;
    n3   = w3 ^ n2;
    rk_d = {n0, n1, n2, n3};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rk_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            rk_q    <= key_in;
            idx_q   <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          // rk/rk_idx keep their round-10 values once the run ends
          if (idx_q == IDX_W'(LAST_IDX)) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            rk_q    <= rk_d;
            idx_q   <= idx_d;
            done_q  <= (idx_d == IDX_W'(LAST_IDX));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rk       = rk_q;
  assign rk_idx   = idx_q;
  assign rk_valid = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// Self-checking bench for aes_key_sched: scoreboard of expected round keys
// built from an independent GF(2^8) S-box and FIPS-197 key expansion model.
module tb_aes_key_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] rk;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [127:0] rk;
    logic [3:0]   idx;
    logic         done;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_exp;
  exp_t       mon_got;
  logic [7:0] sbox_tbl [256];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_sched dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .rk       (rk),
    .rk_idx   (rk_idx),
    .rk_valid (rk_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from first principles: multiplicative inverse then affine map
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] x;
    for (int v = 0; v < 256; v++) begin
      x   = 8'(v);
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
      sbox_tbl[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^
                    rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = key[127:96];
    w[1] = key[95:64];
    w[2] = key[63:32];
    w[3] = key[31:0];
    rc   = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]],
              sbox_tbl[t[31:24]]} ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic push_key(input logic [127:0] key);
    exp_t e;
    for (int r = 0; r <= 10; r++) begin
      e.rk   = round_key(key, r);
      e.idx  = 4'(r);
      e.done = (r == 10);
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Scoreboard: every valid round key must match the next expected entry
  always @(negedge clk) begin
    if (rk_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: rk_idx=%0d rk=%h with no expected entry", rk_idx, rk);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_got = '{rk: rk, idx: rk_idx, done: done};
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL sb_round: got idx=%0d rk=%h done=%0b, expected idx=%0d rk=%h done=%0b",
                   mon_got.idx, mon_got.rk, mon_got.done, mon_exp.idx, mon_exp.rk, mon_exp.done);
        end
      end
    end
  end

  task automatic test_reset();
    rst    = 1'b1;
    start  = 1'b1;
    key_in = FIPS_KEY;
    repeat (2) @(negedge clk);
    checks++;
    if ({rk, rk_idx, rk_valid, busy, done} !== 135'd0) begin
      errors++;
      $display("FAIL reset_state: rk=%h idx=%0d valid=%0b busy=%0b done=%0b, expected all 0",
               rk, rk_idx, rk_valid, busy, done);
    end
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rk_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_start_discard: valid=%0b busy=%0b, expected 0 0", rk_valid, busy);
    end
  endtask

  // Known-answer run plus cycle-exact timing of valid/busy/done
  task automatic test_known(input logic [127:0] key, input logic [127:0] r1,
                            input logic [127:0] r10, input string name);
    @(negedge clk);
    key_in = key;
    start  = 1'b1;
    push_key(key);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (k <= 11) begin
        if ({rk_valid, busy, done, rk_idx} !== {1'b1, 1'b1, (k == 11), 4'(k - 1)}) begin
          errors++;
          $display("FAIL %s_timing cycle N+%0d: valid=%0b busy=%0b done=%0b idx=%0d, expected 1 1 %0b %0d",
                   name, k, rk_valid, busy, done, rk_idx, (k == 11), k - 1);
        end
      end else if ({rk_valid, busy, done, rk_idx, rk} !== {3'b000, 4'd10, r10}) begin
        errors++;
        $display("FAIL %s_return_idle: valid=%0b busy=%0b done=%0b idx=%0d rk=%h, expected 0 0 0 10 %h",
                 name, rk_valid, busy, done, rk_idx, rk, r10);
      end
      if (k == 1) begin
        checks++;
        if (rk !== key) begin
          errors++;
          $display("FAIL %s_rk0: rk=%h expected %h", name, rk, key);
        end
      end
      if (k == 2) begin
        checks++;
        if (rk !== r1) begin
          errors++;
          $display("FAIL %s_rk1: rk=%h expected %h", name, rk, r1);
        end
      end
      if (k == 11) begin
        checks++;
        if (rk !== r10) begin
          errors++;
          $display("FAIL %s_rk10: rk=%h expected %h", name, rk, r10);
        end
      end
    end
  endtask

  task automatic test_busy_lockout();
    logic [127:0] key_a;
    logic [127:0] key_b;
    key_a = rand128();
    key_b = rand128();
    @(negedge clk);
    key_in = key_a;
    start  = 1'b1;
    push_key(key_a);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start  = (k == 5);
      key_in = (k == 5) ? key_b : rand128();
      if (k == 5) begin
        checks++;
        if (rk_idx !== 4'd4) begin
          errors++;
          $display("FAIL lockout_idx: rk_idx=%0d expected 4", rk_idx);
        end
      end
      if (k >= 12) begin
        checks++;
        if ({rk_valid, busy} !== 2'b00) begin
          errors++;
          $display("FAIL lockout_no_restart cycle N+%0d: valid=%0b busy=%0b, expected 0 0",
                   k, rk_valid, busy);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [127:0] key_c;
    int           vcnt;
    key_c = rand128();
    @(negedge clk);
    key_in = key_c;
    start  = 1'b1;
    push_key(key_c);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (rk_idx !== 4'd6) begin
      errors++;
      $display("FAIL midreset_idx: rk_idx=%0d expected 6", rk_idx);
    end
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    checks++;
    if ({rk, rk_idx, rk_valid, busy, done} !== 135'd0) begin
      errors++;
      $display("FAIL midreset_outputs: rk=%h idx=%0d valid=%0b busy=%0b done=%0b, expected all 0",
               rk, rk_idx, rk_valid, busy, done);
    end
    exp_q.delete();
    rst   = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({rk_valid, busy} !== 2'b00) begin
        errors++;
        $display("FAIL midreset_abort: valid=%0b busy=%0b, expected 0 0", rk_valid, busy);
      end
    end
    key_c = rand128();
    @(negedge clk);
    key_in = key_c;
    start  = 1'b1;
    push_key(key_c);
    vcnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (rk_valid === 1'b1) vcnt++;
    end
    checks++;
    if (vcnt != 11) begin
      errors++;
      $display("FAIL midreset_restart_count: valid cycles=%0d expected 11", vcnt);
    end
  endtask

  task automatic test_back_to_back();
    int dcnt;
    @(negedge clk);
    key_in = FIPS_KEY;
    start  = 1'b1;
    push_key(FIPS_KEY);
    push_key(FIPS_KEY);
    dcnt = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 14) start = 1'b0;
      if (done === 1'b1) dcnt++;
      checks++;
      if ({rk_valid, done} !== {(k != 12 && k != 24), (k == 11 || k == 23)}) begin
        errors++;
        $display("FAIL b2b_pattern cycle N+%0d: valid=%0b done=%0b, expected %0b %0b", k,
                 rk_valid, done, (k != 12 && k != 24), (k == 11 || k == 23));
      end
    end
    checks++;
    if (dcnt != 2) begin
      errors++;
      $display("FAIL b2b_done_count: done pulses=%0d expected 2", dcnt);
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    key_in = '0;
    build_sbox();
    test_reset();
    test_known(FIPS_KEY, FIPS_R1, FIPS_R10, "fips");
    test_known(128'd0, ZERO_R1, ZERO_R10, "zero");
    test_busy_lockout();
    test_mid_reset();
    test_back_to_back();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected round keys never produced", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_sched.md
AES_KEY_SCHED -- requirements
Module: aes_key_sched

Interface
REQ-001 The block SHALL have no parameters; it is fixed to AES-128 (Nk=4, 10 rounds).
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to expand key_in; sampled each rising edge.
REQ-005 key_in  input  128  cipher key; word w0 = key_in[127:96], w3 = key_in[31:0].
REQ-006 rk  output  128  current round key, same word order as key_in.
REQ-007 rk_idx  output  4  round number of rk, 0..10.
REQ-008 rk_valid  output  1  rk/rk_idx hold a valid round key this cycle.
REQ-009 busy  output  1  expansion in progress; start is ignored.
REQ-010 done  output  1  one-cycle pulse coincident with the round-10 key.

Function
REQ-011 The FSM SHALL have two states: IDLE and RUN.
REQ-012 In IDLE, start=1 SHALL latch key_in into rk, set rk_idx=0, rk_valid=1, busy=1 and enter RUN on that same edge.
REQ-013 Round key 0 SHALL equal the latched key_in, unmodified, and SHALL appear in the cycle after the start edge (latency 1).
REQ-014 In RUN, each edge SHALL replace rk with the next round key and increment rk_idx by 1.
REQ-015 Next key from w0..w3: t = SubWord(RotWord(w3)) XOR {rcon[rk_idx+1],24'h0}; w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
REQ-016 RotWord SHALL rotate bytes left by one ({b0,b1,b2,b3} -> {b1,b2,b3,b0}); SubWord SHALL apply the FIPS-197 S-box to each of the 4 bytes combinationally.
REQ-017 rcon for rounds 1..10 SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex).
REQ-018 Round keys 0..10 SHALL appear on 11 consecutive cycles with rk_valid=1 and no gaps.
REQ-019 done SHALL be 1 only in the cycle rk_idx=10 and rk_valid=1.
REQ-020 On the edge after round 10, the FSM SHALL return to IDLE with rk_valid=0, busy=0, done=0; rk and rk_idx SHALL hold their round-10 values.
REQ-021 start=1 while busy=1 SHALL be ignored, with no restart and no queueing; key_in changes during RUN SHALL have no effect.
REQ-022 start=1 in the return-to-IDLE cycle (busy=0) SHALL begin a new expansion, giving round key 0 of the new key on the following cycle.
REQ-023 start held high continuously SHALL produce back-to-back expansions separated by exactly one idle cycle.
REQ-024 rk_idx SHALL never exceed 10, and no rcon index outside 1..10 SHALL be used.

Reset
REQ-025 rst=1 at a rising edge SHALL force IDLE with rk=0, rk_idx=0, rk_valid=0, busy=0, done=0.
REQ-026 rst SHALL take priority over start and over any RUN activity; a reset mid-expansion SHALL abort it with no further rk_valid until a new start.
REQ-027 start asserted together with rst SHALL be discarded.

Verification
REQ-028 FIPS-197 vector: start with key_in=2b7e151628aed2a6abf7158809cf4f3c -> idx0 rk=key_in; idx1 rk=a0fafe1788542cb123a339392a6c7605; idx10 rk=d014f9a8c9ee2589e13f0cc8b6630ca6 with done=1.
REQ-029 Zero key: key_in=0 -> idx1 rk=62636363626363636263636362636363; idx10 rk=b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-030 Busy lockout: pulse start with key A, then pulse start with key B at idx 4 -> key A sequence completes unchanged and B is not expanded.
REQ-031 Mid-run reset: assert rst at idx 6 -> next cycle all outputs 0; a later start yields a correct full 11-key sequence.
REQ-032 Continuous start with the FIPS key -> 11 valid cycles, 1 idle cycle, then 11 valid cycles; done pulses exactly twice per 23 cycles.
REQ-033 Timing check: start edge at cycle N -> rk_valid is 1 for cycles N+1..N+11, done is 1 at N+11, busy is 0 at N+12.
